// File: rtl/rst_ctrl_pkg.sv
// Shared types and constants for the Sonata system reset controller.
//   rst_state_e   : controller FSM state encoding
//   Cause*        : bit positions within the one-hot reset cause vector
//   ResetCountW   : width of the saturating reset counter
package rst_ctrl_pkg;

   localparam int unsigned CauseW      = 4;
   localparam int unsigned ResetCountW = 8;

   localparam int unsigned CausePor  = 0;
   localparam int unsigned CauseLock = 1;
   localparam int unsigned CauseBtn  = 2;
   localparam int unsigned CauseSw   = 3;

   typedef enum logic [1:0] {
      StWaitLock = 2'd0,
      StHold     = 2'd1,
      StBtn      = 2'd2,
      StRun      = 2'd3
   } rst_state_e;

   // One-hot cause vector with only bit idx set
   function automatic logic [CauseW-1:0] cause_onehot(input int unsigned idx);
      return CauseW'(1) << idx;
   endfunction

endpackage

// File: rtl/rst_debounce.sv
// Synchroniser chain followed by a stability filter.
//   clk_i, rst_ni : clock and synchronous active-low reset
//   async_i       : asynchronous (possibly bouncy) level input
//   stable_o      : synchronised level, updated only after DebounceCycles
//                   consecutive cycles of disagreement with the current value
module rst_debounce #(
   parameter int unsigned SyncStages     = 2,
   parameter int unsigned DebounceCycles = 50000,
   parameter logic        RstVal         = 1'b1
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic async_i,
   output logic stable_o
);

   localparam int unsigned CntW = (DebounceCycles > 1) ? $clog2(DebounceCycles) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

   logic [SyncStages-1:0] sync_q;
   logic [CntW-1:0]       cnt_q;
   logic                  stable_q;
   logic                  sync_s;

   assign sync_s   = sync_q[SyncStages-1];
   assign stable_o = stable_q;

   // Metastability chain; bit 0 samples the raw input
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync_q <= {SyncStages{RstVal}};
      end else begin
         sync_q <= {sync_q[SyncStages-2:0], async_i};
      end
   end

   // Accept a new level only once it has disagreed for DebounceCycles cycles
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         cnt_q    <= '0;
         stable_q <= RstVal;
      end else if (sync_s != stable_q) begin
         if (cnt_q == CntMax) begin
            stable_q <= sync_s;
            cnt_q    <= '0;
         end else begin
            cnt_q <= cnt_q + CntW'(1);
         end
      end else begin
         cnt_q <= '0;
      end
   end

endmodule

// File: rtl/rst_ctrl_sonata.sv
// System reset controller for the clk_sys domain.
//   clk_i, rst_ni  : clock and synchronous active-low controller reset
//   pll_locked_i   : asynchronous PLL lock indication
//   ext_rst_ni     : asynchronous, bouncy board reset button (active-low)
//   sw_rst_req_i   : single-cycle software reset request
//   rst_sys_no     : registered active-low system reset, high only in RUN
//   reset_cause_o  : one-hot cause of the last exit from RUN {sw,btn,lock,por}
//   reset_count_o  : saturating count of exits from RUN since rst_ni
module rst_ctrl_sonata
   import rst_ctrl_pkg::*;
#(
   parameter int unsigned SyncStages     = 2,
   parameter int unsigned DebounceCycles = 50000,
   parameter int unsigned HoldCycles     = 1024
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   input  logic                   pll_locked_i,
   input  logic                   ext_rst_ni,
   input  logic                   sw_rst_req_i,
   output logic                   rst_sys_no,
   output logic [CauseW-1:0]      reset_cause_o,
   output logic [ResetCountW-1:0] reset_count_o
);

   localparam int unsigned HoldW = (HoldCycles > 1) ? $clog2(HoldCycles) : 1;
   localparam logic [HoldW-1:0] HoldMax = HoldW'(HoldCycles - 1);

   logic [SyncStages-1:0]  lock_sync_q;
   logic                   lock_s;
   logic                   btn_stable;
   logic                   btn_pressed;

   rst_state_e             state_q, state_d;
   logic [HoldW-1:0]       hold_cnt_q, hold_cnt_d;
   logic [CauseW-1:0]      cause_q, cause_d, exit_cause;
   logic [ResetCountW-1:0] count_q, count_d;
   logic                   rst_sys_q;

   assign lock_s        = lock_sync_q[SyncStages-1];
   assign btn_pressed   = ~btn_stable;
   assign rst_sys_no    = rst_sys_q;
   assign reset_cause_o = cause_q;
   assign reset_count_o = count_q;

   // Lock synchroniser; resets to "unlocked"
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         lock_sync_q <= '0;
      end else begin
         lock_sync_q <= {lock_sync_q[SyncStages-2:0], pll_locked_i};
      end
   end

   // Button synchroniser + debounce; resets to "released"
   rst_debounce #(
      .SyncStages     (SyncStages),
      .DebounceCycles (DebounceCycles),
      .RstVal         (1'b1)
   ) u_btn_debounce (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .async_i  (ext_rst_ni),
      .stable_o (btn_stable)
   );

   // Next state, hold counter and cause/count bookkeeping
   always_comb begin
      state_d    = state_q;
      hold_cnt_d = '0;
      cause_d    = cause_q;
      count_d    = count_q;
      exit_cause = '0;

      case (state_q)
         StWaitLock: begin
            if (lock_s) state_d = StHold;
         end
         StHold: begin
            if (!lock_s) begin
               state_d = StWaitLock;
            end else if (btn_pressed) begin
               state_d = StBtn;
            end else if (hold_cnt_q == HoldMax) begin
               state_d = StRun;
            end else begin
               hold_cnt_d = hold_cnt_q + HoldW'(1);
            end
         end
         StBtn: begin
            if (!lock_s) begin
               state_d = StWaitLock;
            end else if (!btn_pressed) begin
               state_d = StHold;
            end
         end
         StRun: begin
            if (!lock_s) begin
               state_d    = StWaitLock;
               exit_cause = cause_onehot(CauseLock);
            end else if (btn_pressed) begin
               state_d    = StBtn;
               exit_cause = cause_onehot(CauseBtn);
            end else if (sw_rst_req_i) begin
               state_d    = StHold;
               exit_cause = cause_onehot(CauseSw);
            end
         end
         default: state_d = StWaitLock;
      endcase

      // Only an exit from RUN is recorded; re-triggers inside reset are not
      if (state_q == StRun && state_d != StRun) begin
         cause_d = exit_cause;
         if (count_q != '1) count_d = count_q + ResetCountW'(1);
      end
   end

   // State and output registers
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= StWaitLock;
         hold_cnt_q <= '0;
         cause_q    <= cause_onehot(CausePor);
         count_q    <= '0;
         rst_sys_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_cnt_q <= hold_cnt_d;
         cause_q    <= cause_d;
         count_q    <= count_d;
         rst_sys_q  <= (state_d == StRun);
      end
   end

endmodule

// File: tb/tb_rst_ctrl_sonata.sv
// Self-checking bench for rst_ctrl_sonata (SyncStages=2, DebounceCycles=8,
// HoldCycles=16). Each vector holds inputs for n edges, then checks outputs.
module tb_rst_ctrl_sonata;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       pll_locked_i;
   logic       ext_rst_ni;
   logic       sw_rst_req_i;
   logic       rst_sys_no;
   logic [3:0] reset_cause_o;
   logic [7:0] reset_count_o;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   rst_ctrl_sonata #(
      .SyncStages     (2),
      .DebounceCycles (8),
      .HoldCycles     (16)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .pll_locked_i  (pll_locked_i),
      .ext_rst_ni    (ext_rst_ni),
      .sw_rst_req_i  (sw_rst_req_i),
      .rst_sys_no    (rst_sys_no),
      .reset_cause_o (reset_cause_o),
      .reset_count_o (reset_count_o)
   );

   typedef struct {
      logic        rst_n;
      logic        pll;
      logic        btn;
      logic        sw;
      int unsigned n;
      logic        exp_rst;
      logic [3:0]  exp_cause;
      logic [7:0]  exp_count;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic rst_n, input logic pll, input logic btn, input logic sw,
                      input int unsigned n, input logic er, input logic [3:0] ec,
                      input logic [7:0] en);
      vec_t v;
      v.rst_n = rst_n; v.pll = pll; v.btn = btn; v.sw = sw; v.n = n;
      v.exp_rst = er; v.exp_cause = ec; v.exp_count = en;
      vecs.push_back(v);
   endtask

   // Advance one rising edge and settle away from it
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string name, input logic er, input logic [3:0] ec,
                        input logic [7:0] en);
      checks++;
      if (rst_sys_no !== er || reset_cause_o !== ec || reset_count_o !== en) begin
         errors++;
         $display("FAIL %s: got rst_sys_no=%b cause=%b count=%0d, want rst_sys_no=%b cause=%b count=%0d",
                  name, rst_sys_no, reset_cause_o, reset_count_o, er, ec, en);
      end
   endtask

   initial begin
      rst_ni = 1'b0; pll_locked_i = 1'b0; ext_rst_ni = 1'b1; sw_rst_req_i = 1'b0;

      //   rst pll btn sw  n   rst cause    count
      // reset values, then lock -> release on 19th edge
      add(0, 0, 1, 0,  3, 0, 4'b0001, 0);
      add(1, 0, 1, 0,  5, 0, 4'b0001, 0);
      add(1, 1, 1, 0, 18, 0, 4'b0001, 0);
      add(1, 1, 1, 0,  1, 1, 4'b0001, 0);
      // one-cycle lock loss: low on 3rd edge, re-release 19 edges after re-lock
      add(1, 0, 1, 0,  1, 1, 4'b0001, 0);
      add(1, 1, 1, 0,  1, 1, 4'b0001, 0);
      add(1, 1, 1, 0,  1, 0, 4'b0010, 1);
      add(1, 1, 1, 0, 16, 0, 4'b0010, 1);
      add(1, 1, 1, 0,  1, 1, 4'b0010, 1);
      // 5-cycle button glitch rejected
      add(1, 1, 0, 0,  5, 1, 4'b0010, 1);
      add(1, 1, 1, 0, 20, 1, 4'b0010, 1);
      // 20-cycle press: low on 11th edge; release debounced + 16 hold
      add(1, 1, 0, 0, 10, 1, 4'b0010, 1);
      add(1, 1, 0, 0,  1, 0, 4'b0100, 2);
      add(1, 1, 0, 0,  9, 0, 4'b0100, 2);
      add(1, 1, 1, 0, 10, 0, 4'b0100, 2);
      add(1, 1, 1, 0, 16, 0, 4'b0100, 2);
      add(1, 1, 1, 0,  1, 1, 4'b0100, 2);
      // software reset: low next edge, high 16 edges later
      add(1, 1, 1, 1,  1, 0, 4'b1000, 3);
      add(1, 1, 1, 0, 15, 0, 4'b1000, 3);
      add(1, 1, 1, 0,  1, 1, 4'b1000, 3);
      // second sw pulse during HOLD is ignored
      add(1, 1, 1, 1,  1, 0, 4'b1000, 4);
      add(1, 1, 1, 0,  3, 0, 4'b1000, 4);
      add(1, 1, 1, 1,  1, 0, 4'b1000, 4);
      add(1, 1, 1, 0, 11, 0, 4'b1000, 4);
      add(1, 1, 1, 0,  1, 1, 4'b1000, 4);
      // lock loss during HOLD changes neither cause nor count
      add(1, 1, 1, 1,  1, 0, 4'b1000, 5);
      add(1, 0, 1, 0,  3, 0, 4'b1000, 5);
      add(1, 1, 1, 0, 18, 0, 4'b1000, 5);
      add(1, 1, 1, 0,  1, 1, 4'b1000, 5);
      // lock loss together with button press in RUN: cause is lock loss
      add(1, 0, 0, 0,  3, 0, 4'b0010, 6);
      add(1, 1, 1, 0, 18, 0, 4'b0010, 6);
      add(1, 1, 1, 0,  1, 1, 4'b0010, 6);
      // rst_ni during RUN; lock while in reset is ignored
      add(0, 1, 1, 0,  1, 0, 4'b0001, 0);
      add(0, 1, 1, 0,  5, 0, 4'b0001, 0);
      add(1, 1, 1, 0, 18, 0, 4'b0001, 0);
      add(1, 1, 1, 0,  1, 1, 4'b0001, 0);
      // rst_ni during HOLD
      add(1, 1, 1, 1,  1, 0, 4'b1000, 1);
      add(1, 1, 1, 0,  5, 0, 4'b1000, 1);
      add(0, 1, 1, 0,  1, 0, 4'b0001, 0);
      add(1, 1, 1, 0, 18, 0, 4'b0001, 0);
      add(1, 1, 1, 0,  1, 1, 4'b0001, 0);

      foreach (vecs[i]) begin
         rst_ni       = vecs[i].rst_n;
         pll_locked_i = vecs[i].pll;
         ext_rst_ni   = vecs[i].btn;
         sw_rst_req_i = vecs[i].sw;
         repeat (vecs[i].n) tick();
         check($sformatf("vec%0d", i), vecs[i].exp_rst, vecs[i].exp_cause, vecs[i].exp_count);
      end

      // Count saturation: 300 software resets from count 0
      for (int i = 0; i < 300; i++) begin
         logic [7:0] exp_n;
         exp_n = (i + 1 > 255) ? 8'd255 : 8'(i + 1);
         sw_rst_req_i = 1'b1;
         tick();
         sw_rst_req_i = 1'b0;
         if (i == 0 || i == 299) check($sformatf("sat_hold%0d", i), 1'b0, 4'b1000, exp_n);
         repeat (16) tick();
         check($sformatf("sat%0d", i), 1'b1, 4'b1000, exp_n);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
